ex_pipe_ctrl: RTL
=================

Name: ex_pipe_ctrl

Overview:
Central pipeline controller for the 5-stage ARM core. It sits beside the EX stage and sequences the whole pipe. It detects RAW hazards between the ID-stage sources and the EX/MEM destinations and inserts bubbles. It also flushes IF/ID on a taken branch resolved in EX, and freezes every stage while the SRAM memory stage is busy. It keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

Parameters:
CNT_W, 16, width of stall-cycle counter
TIMEOUT, 64, max MEM_WAIT cycles before mem_err sets (must be ≥1)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-low
id_valid  in  1  ID holds a real instruction
src1  in  4  ID source register Rn
src2  in  4  ID source register Rm/Rd
two_src  in  1  ID instruction reads src2
ex_dest  in  4  EX destination register
ex_wb_en  in  1  EX instruction writes back
ex_mem_r_en  in  1  EX instruction is a load
mem_dest  in  4  MEM destination register
mem_wb_en  in  1  MEM instruction writes back
branch_taken  in  1  EX resolved a taken branch this cycle
mem_req  in  1  MEM stage issues SRAM access
mem_ready  in  1  SRAM access completes this cycle
freeze_if  out  1  hold PC and IF/ID register
freeze_id  out  1  hold ID/EX register
freeze_back  out  1  hold EX/MEM and MEM/WB registers
flush_if  out  1  clear IF/ID to bubble
flush_id  out  1  clear ID/EX to bubble
stall_cnt  out  CNT_W  saturating count of hazard-stall cycles
mem_err  out  1  sticky: SRAM wait exceeded TIMEOUT

Behaviour:
- Reset (rst=0, async): state=RUN; wait_cnt=0; stall_cnt=0; mem_err=0. All combinational outputs are 0 while in RUN with inputs idle.
- FSM states: RUN, MEM_WAIT.
  - RUN→MEM_WAIT when mem_req && !mem_ready.
  - MEM_WAIT→RUN when mem_ready.
  - mem_req && mem_ready in the same RUN cycle stays in RUN (zero-wait access).
- Hazard detection is combinational and gated by id_valid:
  - hz_ex = ex_wb_en && (src1==ex_dest || (two_src && src2==ex_dest))
  - hz_mem is the same expression using mem_wb_en and mem_dest.
- hazard_stall = hz_ex || hz_mem (macro-dependent, see Optional Feature).
- Output priority, highest first:
  1. Memory freeze: state==MEM_WAIT, or (RUN && mem_req && !mem_ready). Drives freeze_if=freeze_id=freeze_back=1, flush_*=0. branch_taken and hazards are ignored; EX is held, so they are re-evaluated after release.
  2. branch_taken drives flush_if=1, flush_id=1, no freezes. A coincident hazard stall is discarded.
  3. hazard_stall drives freeze_if=1, freeze_id=0, flush_id=1 (bubble into EX). Zero-latency, same cycle.
  4. Otherwise all outputs are 0.
- stall_cnt increments by 1 on each cycle with case-3 active, and saturates at all-ones.
- wait_cnt: cleared when entering MEM_WAIT, +1 per MEM_WAIT cycle. mem_err sets when wait_cnt reaches TIMEOUT-1 and mem_ready=0. mem_err clears only on reset. The FSM keeps waiting after mem_err sets.
- Register r0..r15 compare is a full 4-bit equality; r15 gets no special treatment.
- Reset asserted mid-MEM_WAIT returns to RUN immediately and drops all freezes.

Optional Feature:
Macro FORWARD_EN.
- Defined: forwarding unit present; hazard_stall = hz_ex && ex_mem_r_en (load-use only), one bubble.
- Undefined: hazard_stall = hz_ex || hz_mem; up to two bubbles per dependency.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package ex_ctrl_pkg: state enum {RUN, MEM_WAIT}, REG_IDX_W=4, default CNT_W/TIMEOUT constants.
- One natural sub-module, hazard_detect: purely combinational hz_ex/hz_mem/hazard_stall, with the FORWARD_EN ifdef isolated inside.
- FSM, counters and priority mux stay in ex_pipe_ctrl.

Test Plan:
- Load-use: ex_mem_r_en=1, ex_dest=3, src1=3, id_valid=1 → freeze_if=1, flush_id=1 for 1 cycle; stall_cnt 0→1 (both builds).
- MEM-stage RAW: mem_wb_en=1, mem_dest=5, two_src=1, src2=5, ex_wb_en=0 → no FORWARD_EN: stall asserted; FORWARD_EN: all outputs 0.
- Branch vs stall: branch_taken=1 with a load-use hazard in the same cycle → flush_if=flush_id=1, freeze_if=0, stall_cnt unchanged.
- SRAM wait: mem_req=1, mem_ready low for 3 cycles then high → freeze_* =1 for 4 cycles total incl. the ready cycle; RUN on the next cycle; a branch_taken held during the freeze is ignored until release.
- Timeout: TIMEOUT=4, mem_ready held low for 6 cycles → mem_err rises after the 4th MEM_WAIT cycle and stays high after mem_ready; clears only on rst=0.
- Saturation/reset: CNT_W=2, hazard held 5 cycles → stall_cnt=3; async rst pulse mid-MEM_WAIT → outputs 0 and state=RUN without a clock edge.

Source files
------------

// File: rtl/ex_ctrl_pkg.sv
// Shared types and constants for the EX-stage pipeline controller.
package ex_ctrl_pkg;

  localparam int REG_IDX_W   = 4;
  localparam int CNT_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  // Full-width register index compare; r15 is not special-cased.
  function automatic logic reg_match(input logic [REG_IDX_W-1:0] a,
                                     input logic [REG_IDX_W-1:0] b);
    return (a == b);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW hazard detection between ID sources and EX/MEM destinations.
// FORWARD_EN selects load-use-only stalling (forwarding unit present).
module hazard_detect
  import ex_ctrl_pkg::*;
(
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] src1,
  input  logic [REG_IDX_W-1:0] src2,
  input  logic                 two_src,
  input  logic [REG_IDX_W-1:0] ex_dest,
  input  logic                 ex_wb_en,
  input  logic                 ex_mem_r_en,
  input  logic [REG_IDX_W-1:0] mem_dest,
  input  logic                 mem_wb_en,
  output logic                 hz_ex,
  output logic                 hz_mem,
  output logic                 hazard_stall
);

`ifndef FORWARD_EN
  logic unused_s;
  assign unused_s = ex_mem_r_en;
`endif

  // Source/destination overlap against the EX and MEM writers.
  always_comb begin
    hz_ex  = id_valid && ex_wb_en &&
             (reg_match(src1, ex_dest) || (two_src && reg_match(src2, ex_dest)));
    hz_mem = id_valid && mem_wb_en &&
             (reg_match(src1, mem_dest) || (two_src && reg_match(src2, mem_dest)));
`ifdef FORWARD_EN
    hazard_stall = hz_ex && ex_mem_r_en;
`else
    hazard_stall = hz_ex || hz_mem;
`endif
  end

endmodule

// File: rtl/ex_pipe_ctrl.sv
// Pipeline sequencer: memory freeze FSM, branch flush, hazard bubbles, stall/timeout tracking.
// Optional build macro FORWARD_EN (load-use-only stalls, see hazard_detect).
module ex_pipe_ctrl
  import ex_ctrl_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] src1,
  input  logic [REG_IDX_W-1:0] src2,
  input  logic                 two_src,
  input  logic [REG_IDX_W-1:0] ex_dest,
  input  logic                 ex_wb_en,
  input  logic                 ex_mem_r_en,
  input  logic [REG_IDX_W-1:0] mem_dest,
  input  logic                 mem_wb_en,
  input  logic                 branch_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 freeze_if,
  output logic                 freeze_id,
  output logic                 freeze_back,
  output logic                 flush_if,
  output logic                 flush_id,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic                 mem_err
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic               err_q, err_d;
  logic               mem_freeze_s;
  logic               hz_ex_s, hz_mem_s, hazard_stall_s;

  hazard_detect u_hazard_detect (
    .id_valid     (id_valid),
    .src1         (src1),
    .src2         (src2),
    .two_src      (two_src),
    .ex_dest      (ex_dest),
    .ex_wb_en     (ex_wb_en),
    .ex_mem_r_en  (ex_mem_r_en),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .hz_ex        (hz_ex_s),
    .hz_mem       (hz_mem_s),
    .hazard_stall (hazard_stall_s)
  );

  // Next-state logic and prioritised pipeline control outputs.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    stall_d      = stall_q;
    err_d        = err_q;
    mem_freeze_s = 1'b0;
    freeze_if    = 1'b0;
    freeze_id    = 1'b0;
    freeze_back  = 1'b0;
    flush_if     = 1'b0;
    flush_id     = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          state_d      = MEM_WAIT;
          wait_d       = '0;
          mem_freeze_s = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        mem_freeze_s = 1'b1;
        if (!mem_ready && (wait_q == WAIT_LAST)) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        // Counter parks at its last value; the FSM keeps waiting past the timeout.
        if (wait_q != WAIT_LAST) begin
          wait_d = wait_q + WAIT_W'(1);
        end else begin
          wait_d = wait_q;
        end
        if (mem_ready) begin
          state_d = RUN;
        end else begin
          state_d = MEM_WAIT;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (!rst) begin
      mem_freeze_s = 1'b0;
    end else if (mem_freeze_s) begin
      freeze_if   = 1'b1;
      freeze_id   = 1'b1;
      freeze_back = 1'b1;
    end else if (branch_taken) begin
      flush_if = 1'b1;
      flush_id = 1'b1;
    end else if (hazard_stall_s) begin
      freeze_if = 1'b1;
      flush_id  = 1'b1;
      if (!(&stall_q)) begin
        stall_d = stall_q + CNT_W'(1);
      end else begin
        stall_d = stall_q;
      end
    end else begin
      stall_d = stall_q;
    end
  end

  // State, wait/stall counters and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      wait_q  <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign stall_cnt = stall_q;
  assign mem_err   = err_q;

endmodule
